// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: sequencer states and default
// timing/divider constants.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABILIZE  = 2'd1,
        REL_PERIPH = 2'd2,
        RUN        = 2'd3
    } seq_state_e;

    localparam int DEF_LOCK_STABLE_CYC = 4096;
    localparam int DEF_CPU_DELAY_CYC   = 256;
    localparam int DEF_CE_DIV          = 12;
    localparam int DEF_FRAC_NUM        = 199;
    localparam int DEF_FRAC_DEN        = 4000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frac_ce_gen.sv
// Fractional clock-enable generator: FRAC_NUM single-cycle pulses per FRAC_DEN
// cycles, held idle with the accumulator cleared while run is low.
module frac_ce_gen
    import pll_seq_pkg::*;
#(
    parameter int FRAC_NUM = DEF_FRAC_NUM,
    parameter int FRAC_DEN = DEF_FRAC_DEN
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic run,
    output logic ce
);

    // One extra bit so acc + FRAC_NUM (< 2*FRAC_DEN) never overflows.
    localparam int ACC_W = $clog2(FRAC_DEN) + 1;

    generate
        if (FRAC_NUM >= FRAC_DEN) begin : g_bad_ratio
            $error("frac_ce_gen: FRAC_NUM must be smaller than FRAC_DEN");
        end
    endgenerate

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    always_comb begin
        sum   = acc_q + ACC_W'(FRAC_NUM);
        wrap  = (sum >= ACC_W'(FRAC_DEN));
        acc_d = '0;
        if (run) begin
            acc_d = wrap ? (sum - ACC_W'(FRAC_DEN)) : sum;
        end
    end

    assign ce = run && wrap;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Releases peripheral then CPU resets once the PLL has been stably locked, and
// produces integer and fractional clock enables for the released peripherals.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYC = DEF_LOCK_STABLE_CYC,
    parameter int CPU_DELAY_CYC   = DEF_CPU_DELAY_CYC,
    parameter int CE_DIV          = DEF_CE_DIV,
    parameter int FRAC_NUM        = DEF_FRAC_NUM,
    parameter int FRAC_DEN        = DEF_FRAC_DEN
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic       ce_int,
    output logic       ce_frac,
    output logic [7:0] lock_loss_cnt,
    output logic       running
);

    localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYC, CPU_DELAY_CYC) + 1);
    localparam int DIV_W = $clog2(CE_DIV);

    generate
        if (CE_DIV < 2) begin : g_bad_div
            $error("pll_reset_sequencer: CE_DIV must be at least 2");
        end
    endgenerate

    logic [1:0]       sync_q;
    logic             lk;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       loss_q, loss_d;
    logic             periph_rst_q, cpu_rst_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_run;

    assign lk = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end
            end
            STABILIZE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYC - 1)) begin
                    state_d = REL_PERIPH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REL_PERIPH: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(CPU_DELAY_CYC - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Resets are decoded from the next state so they change on the same edge
    // as the state; cpu_rst can only drop when periph_rst is already low.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b00;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            loss_q       <= 8'd0;
            periph_rst_q <= 1'b1;
            cpu_rst_q    <= 1'b1;
            div_q        <= '0;
        end else begin
            sync_q       <= {sync_q[0], pll_locked};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            periph_rst_q <= (state_d == WAIT_LOCK) || (state_d == STABILIZE);
            cpu_rst_q    <= (state_d != RUN);
            div_q        <= div_d;
        end
    end

    assign ce_run = ~periph_rst_q;

    always_comb begin
        div_d = '0;
        if (ce_run && (div_q != DIV_W'(CE_DIV - 1))) begin
            div_d = div_q + 1'b1;
        end
    end

    assign ce_int = ce_run && (div_q == DIV_W'(CE_DIV - 1));

    frac_ce_gen #(
        .FRAC_NUM(FRAC_NUM),
        .FRAC_DEN(FRAC_DEN)
    ) u_frac_ce_gen (
        .clk_sys(clk_sys),
        .rst_n  (rst_n),
        .run    (ce_run),
        .ce     (ce_frac)
    );

    assign periph_rst    = periph_rst_q;
    assign cpu_rst       = cpu_rst_q;
    assign lock_loss_cnt = loss_q;
    assign running       = (state_q == RUN);

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYC, default 4096: consecutive synchronized-locked cycles required before any reset release.
REQ-002 SHALL have parameter CPU_DELAY_CYC, default 256: cycles between peripheral reset release and CPU reset release.
REQ-003 SHALL have parameter CE_DIV, default 12: integer divider for ce_int (72 MHz / 12 = 6 MHz).
REQ-004 SHALL have parameters FRAC_NUM, default 199, and FRAC_DEN, default 4000: fractional ratio for ce_frac (72 MHz * 199/4000 = 3.582 MHz).
REQ-005 SHALL have port clk_sys, input, 1 bit: single system clock (72 MHz PLL output); the only clock in the block.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock flag, asynchronous to clk_sys.
REQ-008 SHALL have port periph_rst, output, 1 bit: active-high reset for video/sound peripherals.
REQ-009 SHALL have port cpu_rst, output, 1 bit: active-high reset for CPUs.
REQ-010 SHALL have port ce_int, output, 1 bit: one-cycle enable pulse every CE_DIV cycles.
REQ-011 SHALL have port ce_frac, output, 1 bit: one-cycle fractional enable pulse.
REQ-012 SHALL have port lock_loss_cnt, output, 8 bits: saturating count of lock losses seen in RUN.
REQ-013 SHALL have port running, output, 1 bit: high only in state RUN.

Function
REQ-014 SHALL synchronize pll_locked through two flops, reset value 0; all logic uses the synchronized value (lk), adding 2 cycles of latency.
REQ-015 SHALL implement states WAIT_LOCK, STABILIZE, REL_PERIPH, RUN.
REQ-016 WAIT_LOCK: both resets high; lk=1 -> STABILIZE with stability counter cleared.
REQ-017 STABILIZE: counter increments each cycle with lk=1; lk=0 -> WAIT_LOCK; counter reaching LOCK_STABLE_CYC-1 -> REL_PERIPH.
REQ-018 REL_PERIPH: periph_rst low, cpu_rst high; delay counter reaching CPU_DELAY_CYC-1 -> RUN; lk=0 -> WAIT_LOCK.
REQ-019 RUN: both resets low, running high.
REQ-020 SHALL, on lk=0 in any state other than WAIT_LOCK, move to WAIT_LOCK and drive both resets high on the next clock edge.
REQ-021 SHALL increment lock_loss_cnt only on RUN->WAIT_LOCK, saturating at 255.
REQ-022 SHALL register periph_rst and cpu_rst; cpu_rst SHALL never be low while periph_rst is high.
REQ-023 ce_int SHALL count 0..CE_DIV-1 and pulse when the count equals CE_DIV-1; pulse spacing exactly CE_DIV cycles.
REQ-024 ce_frac SHALL use an accumulator of width clog2(FRAC_DEN)+1: add FRAC_NUM each cycle; when sum >= FRAC_DEN, subtract FRAC_DEN and pulse; exactly FRAC_NUM pulses per FRAC_DEN cycles.
REQ-025 SHALL run both enable generators only while periph_rst is low and hold them at count 0 with outputs low otherwise.
REQ-026 FRAC_NUM >= FRAC_DEN or CE_DIV < 2 SHALL be a elaboration-time error.

Reset
REQ-027 rst_n low SHALL asynchronously force: state WAIT_LOCK, sync flops 0, periph_rst=1, cpu_rst=1, ce_int=0, ce_frac=0, all counters and accumulator 0, lock_loss_cnt=0, running=0.
REQ-028 SHALL leave reset release unsynchronized in this block; rst_n is released synchronously by the upstream board reset logic.

Structure
REQ-029 SHALL place state enumeration and default divider constants in the shared core package pll_seq_pkg.
REQ-030 SHALL implement the fractional divider as sub-module frac_ce_gen, parameterized by FRAC_NUM/FRAC_DEN, with inputs clk_sys, rst_n, run and output ce.

Verification (LOCK_STABLE_CYC=16, CPU_DELAY_CYC=8)
REQ-031 pll_locked held high from rst_n release -> periph_rst falls at cycle 2+16+1 (+/-1), cpu_rst 8 cycles later, running high with cpu_rst low.
REQ-032 pll_locked glitches low for 3 cycles during STABILIZE -> resets remain high; counter restarts; lock_loss_cnt stays 0.
REQ-033 pll_locked drops in RUN 300 times -> both resets high within 3 cycles each time; lock_loss_cnt saturates at 255.
REQ-034 RUN for 4000 cycles -> exactly 333 ce_int pulses (12-cycle spacing) and exactly 199 ce_frac pulses, spacing 20 or 21 cycles.
REQ-035 rst_n asserted mid-REL_PERIPH -> all outputs at reset values immediately, without waiting for clk_sys.
